// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

  // Loader frame states.
  typedef enum logic [2:0] {
    LD_HDR,
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  // Byte receiver bit-level states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LD_HDR_BYTE = 8'hA5;

  // Oversample divider, rounded to nearest: round(clk_freq / (baud * 16)).
  function automatic int calc_div(input int clk_freq, input int baud);
    int div;
    div = (clk_freq + baud * 8) / (baud * 16);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_imem_loader_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, 16x oversample tick, bit FSM.
// rx_valid / rx_ferr are one-cycle pulses registered after the stop-bit sample.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  rx_state_t        state_q, state_d;
  logic [3:0]       os_q, os_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  assign tick     = (div_q == DIV_W'(DIV - 1));
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

  // Bit FSM: confirm start at mid-bit, then sample every 16 ticks.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          os_d    = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_q == 4'd7) begin
            os_d  = '0;
            bit_d = '0;
            // A line that is back high at mid-bit was a glitch.
            state_d = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            os_d = '0;
            sh_d = {sync2_q, sh_q[7:1]};
            if (bit_q == 3'd7) state_d = RX_STOP;
            else               bit_d   = bit_q + 3'd1;
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (os_q == 4'd15) begin
            state_d = RX_IDLE;
            if (sync2_q) begin
              valid_d = 1'b1;
              data_d  = sh_q;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            os_d = os_q + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State registers; synchronizer resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
      state_q <= RX_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      div_q   <= div_d;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: receives A5 | N_lo N_hi | N LE words | XOR checksum over UART,
// writes words into instruction memory and releases the CPU on a good image.
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int IMEM_AW  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Rx,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam int          IW  = IMEM_AW + 1;
  localparam logic [16:0] CAP = 17'(2 ** IMEM_AW);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  ld_state_t          state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [IW-1:0]      idx_q, idx_d, idx_inc;
  logic [1:0]         cnt_q, cnt_d;
  logic [31:0]        sh_q, sh_d;
  logic [7:0]         csum_q, csum_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        n_len;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk     (CLK),
    .rst     (RST),
    .rx      (Rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  assign n_len      = {rx_data, len_q[7:0]};
  assign idx_inc    = idx_q + IW'(1);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign load_err   = err_q;

  // Frame FSM, word assembler and running checksum.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    if (state_q != LD_DONE && rx_ferr) begin
      state_d = LD_ERR;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        LD_HDR: begin
          if (rx_data == LD_HDR_BYTE) begin
            state_d = LD_LEN0;
            err_d   = 1'b0;
            csum_d  = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        LD_LEN0: begin
          len_d   = {8'h00, rx_data};
          csum_d  = csum_q ^ rx_data;
          state_d = LD_LEN1;
        end
        LD_LEN1: begin
          len_d  = n_len;
          csum_d = csum_q ^ rx_data;
          if ({1'b0, n_len} > CAP) begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end else if (n_len == 16'd0) begin
            state_d = LD_CSUM;
          end else begin
            state_d = LD_DATA;
          end
        end
        LD_DATA: begin
          csum_d = csum_q ^ rx_data;
          sh_d   = {rx_data, sh_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[IMEM_AW-1:0];
            wdata_d = {rx_data, sh_q[31:8]};
            idx_d   = idx_inc;
            if (17'(idx_inc) == {1'b0, len_q}) state_d = LD_CSUM;
          end
        end
        LD_CSUM: begin
          if (rx_data == csum_q) begin
            state_d = LD_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = LD_ERR;
            err_d   = 1'b1;
          end
        end
        LD_ERR:  state_d = LD_HDR;
        default: state_d = state_q;
      endcase
    end
  end

  // Loader registers; reset aborts any partial image and re-asserts hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LD_HDR;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at 16 clocks per bit (DIV = 1).
module tb_uart_imem_loader;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int IMEM_AW  = 8;

  logic               CLK = 1'b0;
  logic               RST;
  logic               Rx;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic               cpu_hold;
  logic               load_done;
  logic               load_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IMEM_AW-1:0] wr_addr[$];
  logic [31:0]        wr_data[$];
  logic [7:0]         frame[$];

  uart_imem_loader #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .IMEM_AW (IMEM_AW)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .Rx        (Rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 CLK = ~CLK;

  // Log every write strobe cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    Rx  = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},    imem_we,    32'd0);
    check({tag, "_addr"},  imem_addr,  32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"},  cpu_hold,   32'd1);
    check({tag, "_done"},  load_done,  32'd0);
    check({tag, "_err"},   load_err,   32'd0);
  endtask

  // One 8N1 byte, 16 clocks per bit, driven on falling edges. With chk_hold
  // set, cpu_hold must still be 1 just after the stop-bit sample edge and 0
  // one cycle after the byte-valid cycle.
  task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit chk_hold);
    @(negedge CLK);
    Rx = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (16) @(negedge CLK);
    end
    Rx = bad_stop ? 1'b0 : 1'b1;
    if (chk_hold) begin
      repeat (11) @(negedge CLK);
      check("hold_before_fall", cpu_hold, 32'd1);
      @(negedge CLK);
      check("hold_after_fall", cpu_hold, 32'd0);
      repeat (4) @(negedge CLK);
    end else begin
      repeat (16) @(negedge CLK);
    end
    Rx = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic send_frame(input bit chk_hold);
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], 1'b0, chk_hold && (i == frame.size() - 1));
    repeat (4) @(negedge CLK);
  endtask

  // Two-word program; good checksum is
  // 02^00^13^05^10^00^93^05^20^00 = B2.
  task automatic build_prog(input logic [7:0] cs);
    frame = {8'hA5, 8'h02, 8'h00,
             8'h13, 8'h05, 8'h10, 8'h00,
             8'h93, 8'h05, 8'h20, 8'h00, cs};
  endtask

  task automatic check_prog_writes(input string tag, input int base);
    check({tag, "_wr_cnt"}, wr_addr.size(), base + 2);
    if (wr_addr.size() >= base + 2) begin
      check({tag, "_addr0"}, wr_addr[base],     32'd0);
      check({tag, "_data0"}, wr_data[base],     32'h0010_0513);
      check({tag, "_addr1"}, wr_addr[base + 1], 32'd1);
      check({tag, "_data1"}, wr_data[base + 1], 32'h0020_0593);
    end
  endtask

  initial begin
    RST = 1'b1;
    Rx  = 1'b1;

    // Reset state.
    do_reset();
    check_reset_vals("rst");

    // Good two-word image.
    build_prog(8'hB2);
    send_frame(1'b1);
    check_prog_writes("good", 0);
    check("good_done", load_done, 32'd1);
    check("good_err",  load_err,  32'd0);
    check("good_hold", cpu_hold,  32'd0);

    // Bad checksum, then a junk byte, then a good retry.
    do_reset();
    build_prog(8'hB3);
    send_frame(1'b0);
    check("badcs_err",    load_err,       32'd1);
    check("badcs_hold",   cpu_hold,       32'd1);
    check("badcs_done",   load_done,      32'd0);
    check("badcs_wr_cnt", wr_addr.size(), 32'd2);
    send_byte(8'h00, 1'b0, 1'b0);
    check("junk_err_kept", load_err, 32'd1);
    build_prog(8'hB2);
    send_frame(1'b1);
    check_prog_writes("retry", 2);
    check("retry_done", load_done, 32'd1);
    check("retry_err",  load_err,  32'd0);

    // Empty image.
    do_reset();
    frame = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(1'b1);
    check("empty_done",   load_done,      32'd1);
    check("empty_wr_cnt", wr_addr.size(), 32'd0);

    // Length over capacity (N = 257).
    do_reset();
    frame = {8'hA5, 8'h01, 8'h01};
    send_frame(1'b0);
    check("big_err",    load_err,       32'd1);
    check("big_hold",   cpu_hold,       32'd1);
    check("big_done",   load_done,      32'd0);
    check("big_wr_cnt", wr_addr.size(), 32'd0);

    // Short low glitch right before a good frame must not start a byte.
    do_reset();
    @(negedge CLK);
    Rx = 1'b0;
    repeat (4) @(negedge CLK);
    Rx = 1'b1;
    repeat (12) @(negedge CLK);
    check("glitch_err", load_err, 32'd0);
    build_prog(8'hB2);
    send_frame(1'b1);
    check_prog_writes("glitch", 0);
    check("glitch_done", load_done, 32'd1);

    // Framing error on the third byte.
    do_reset();
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    check("ferr_err",    load_err,       32'd1);
    check("ferr_hold",   cpu_hold,       32'd1);
    check("ferr_wr_cnt", wr_addr.size(), 32'd0);

    // Reset after word 0 aborts the image; a full frame then loads.
    do_reset();
    build_prog(8'hB2);
    for (int i = 0; i < 7; i++) send_byte(frame[i], 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    check("mid_wr_cnt", wr_addr.size(), 32'd1);
    if (wr_data.size() >= 1) check("mid_data0", wr_data[0], 32'h0010_0513);
    @(negedge CLK);
    RST = 1'b1;
    #2;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    check_reset_vals("post_rst");
    wr_addr.delete();
    wr_data.delete();
    send_frame(1'b1);
    check_prog_writes("reload", 0);
    check("reload_done", load_done, 32'd1);
    check("reload_err",  load_err,  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
